// File: rtl/gpio_input_debounce.sv
// Per-bit input conditioner: two-flop synchroniser, consecutive-cycle debounce
// counter and registered rise/fall strobes for each raw board input.
module gpio_input_debounce #(
    parameter int                    NUM_INPUTS      = 6,
    parameter int                    DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_INPUTS-1:0] RESET_VALUE     = '0
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] debounced_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
    output logic                  any_change
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
    logic [NUM_INPUTS-1:0] stable_q, stable_d;
    logic [NUM_INPUTS-1:0] rise_q, rise_d;
    logic [NUM_INPUTS-1:0] fall_q, fall_d;
    logic                  any_q, any_d;
    logic [CW-1:0]         cnt_q [NUM_INPUTS];
    logic [CW-1:0]         cnt_d [NUM_INPUTS];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = '0;
            // Any cycle of agreement leaves the counter at zero, so counting is strictly consecutive.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        any_d = |{rise_d, fall_d};
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            sync1_q  <= RESET_VALUE;
            sync2_q  <= RESET_VALUE;
            stable_q <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
            // NOTE: the counter array is small flop storage, not RAM, so it is cleared to abandon any count in progress.
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= any_d;
            cnt_q    <= cnt_d;
        end
    end

    assign debounced_out = stable_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign any_change    = any_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Bench for gpio_input_debounce: a filtering instance (4 cycles, reset 0) and a
// pass-through corner instance (1 cycle, reset all ones), scoreboarded against a window model.
module tb_gpio_input_debounce;

    typedef struct {
        int         cyc;
        logic [5:0] lvl;
        logic [5:0] rise;
        logic [5:0] fall;
    } evt_t;

    logic       clk;
    logic       rst_a, rst_b;
    logic [5:0] raw_a, raw_b;
    logic [5:0] dbo_a, rp_a, fp_a, dbo_b, rp_b, fp_b;
    logic       ac_a, ac_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state, per instance (0 = filtering, 1 = pass-through)
    logic [5:0] m_s1 [2];
    logic [5:0] m_s2 [2];
    logic [5:0] m_stab [2];
    logic [5:0] seen [2][$];
    int         last_acc [2][6];
    evt_t       sbq [2][$];

    gpio_input_debounce #(.NUM_INPUTS(6), .DEBOUNCE_CYCLES(4), .RESET_VALUE(6'h00)) dut_a (
        .sys_clk(clk), .rst(rst_a), .raw_in(raw_a), .debounced_out(dbo_a),
        .rise_pulse(rp_a), .fall_pulse(fp_a), .any_change(ac_a)
    );

    gpio_input_debounce #(.NUM_INPUTS(6), .DEBOUNCE_CYCLES(1), .RESET_VALUE(6'h3F)) dut_b (
        .sys_clk(clk), .rst(rst_b), .raw_in(raw_b), .debounced_out(dbo_b),
        .rise_pulse(rp_b), .fall_pulse(fp_b), .any_change(ac_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dcyc(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [5:0] rval(input int k);
        return (k == 0) ? 6'h00 : 6'h3F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A level change is accepted at an edge when the last D synchronised samples
    // observed since the previous acceptance (or reset) all disagree with the stable level.
    task automatic model_step(input int k, input logic r, input logic [5:0] raw);
        logic [5:0] rs, fs;
        int         n, d;
        bit         ok;
        evt_t       e;
        if (r) begin
            m_s1[k]   = rval(k);
            m_s2[k]   = rval(k);
            m_stab[k] = rval(k);
            seen[k].delete();
            for (int c = 0; c < 6; c++) last_acc[k][c] = 0;
        end else begin
            seen[k].push_back(m_s2[k]);
            n  = seen[k].size();
            d  = dcyc(k);
            rs = '0;
            fs = '0;
            for (int c = 0; c < 6; c++) begin
                ok = (n - last_acc[k][c]) >= d;
                for (int j = n - d; ok && j < n; j++)
                    if (seen[k][j][c] == m_stab[k][c]) ok = 0;
                if (ok) begin
                    if (m_stab[k][c]) fs[c] = 1'b1;
                    else              rs[c] = 1'b1;
                    last_acc[k][c] = n;
                end
            end
            m_s2[k]   = m_s1[k];
            m_s1[k]   = raw;
            m_stab[k] = m_stab[k] ^ (rs | fs);
            if ((rs | fs) != 6'h00) begin
                e.cyc  = cyc;
                e.lvl  = m_stab[k];
                e.rise = rs;
                e.fall = fs;
                sbq[k].push_back(e);
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, rst_a, raw_a);
        model_step(1, rst_b, raw_b);
    end

    task automatic mon(input int k, input logic [5:0] dbo, input logic [5:0] rp,
                       input logic [5:0] fp, input logic ac);
        evt_t  e;
        string p;
        p = (k == 0) ? "a" : "b";
        check({p, "_level"}, 32'(dbo), 32'(m_stab[k]));
        if (ac || rp != 6'h00 || fp != 6'h00) begin
            if (sbq[k].size() == 0) begin
                check({p, "_spurious_pulse"}, {19'd0, ac, rp, fp}, 32'd0);
            end else begin
                e = sbq[k].pop_front();
                check({p, "_evt_cycle"}, 32'(cyc), 32'(e.cyc));
                check({p, "_evt_rise"},  32'(rp),  32'(e.rise));
                check({p, "_evt_fall"},  32'(fp),  32'(e.fall));
                check({p, "_evt_any"},   32'(ac),  32'd1);
            end
        end else if (sbq[k].size() != 0 && sbq[k][0].cyc <= cyc) begin
            e = sbq[k].pop_front();
            check({p, "_missed_rise"}, 32'(rp), 32'(e.rise));
            check({p, "_missed_fall"}, 32'(fp), 32'(e.fall));
        end
    endtask

    always @(negedge clk) begin
        mon(0, dbo_a, rp_a, fp_a, ac_a);
        mon(1, dbo_b, rp_b, fp_b, ac_b);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_s1[k]   = rval(k);
            m_s2[k]   = rval(k);
            m_stab[k] = rval(k);
            for (int c = 0; c < 6; c++) last_acc[k][c] = 0;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        raw_a = 6'h3F; raw_b = 6'h3F;
        step(3);
        rst_a = 1'b0; rst_b = 1'b0;
        step(10);

        // all bits fall, then a clean press and release on bit 0
        raw_a = 6'h00; step(10);
        raw_a[0] = 1'b1; step(10);
        raw_a[0] = 1'b0; step(10);

        // bounce on bit 1: high 3, low 1, high 2, then steady high
        raw_a[1] = 1'b1; step(3);
        raw_a[1] = 1'b0; step(1);
        raw_a[1] = 1'b1; step(2);
        step(10);
        raw_a[1] = 1'b0; step(10);

        // simultaneous rise on bits 2 and 5; single-cycle glitch on the pass-through instance
        raw_a = 6'b100100;
        raw_b[4] = 1'b0; step(1);
        raw_b[4] = 1'b1; step(9);
        raw_a = 6'h00; step(10);

        // reset while bit 3 is counting
        raw_a[3] = 1'b1; step(2);
        rst_a = 1'b1; step(2);
        rst_a = 1'b0; step(10);
        raw_a = 6'h00; step(10);

        // randomized traffic: alternating bouncy and quiet stretches, rare resets
        for (int blk = 0; blk < 20; blk++) begin
            int prob;
            prob = (blk % 2 == 0) ? 3 : 25;
            for (int t = 0; t < 40; t++) begin
                for (int c = 0; c < 6; c++) begin
                    if ($urandom_range(prob - 1) == 0) raw_a[c] = ~raw_a[c];
                    if ($urandom_range(prob - 1) == 0) raw_b[c] = ~raw_b[c];
                end
                rst_a = ($urandom_range(149) == 0);
                rst_b = ($urandom_range(149) == 0);
                step(1);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        step(20);

        check("a_drain", 32'(sbq[0].size()), 32'd0);
        check("b_drain", 32'(sbq[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_input_debounce.md
# gpio_input_debounce

Per-bit input conditioning stage placed directly upstream of the GPIO controller's input bank in the GPIO subsystem. It takes raw board inputs (slide switches, push buttons), synchronises them into the `sys_clk` domain and filters contact bounce. It drives clean levels plus single-cycle rise/fall strobes into the controller's `gpio_in_data` field, so button presses produce exactly one edge event per physical press.

## Interface

**Parameters**
- `NUM_INPUTS`, default 6: number of independent input channels (4 buttons + 2 switches).
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz). Legal range is ≥ 1.
- `RESET_VALUE`, default 0: per-bit reset value of `debounced_out`. Width is `NUM_INPUTS`.

**Ports**
- `sys_clk`, input, 1: the single clock. All state is updated on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `raw_in`, input, `NUM_INPUTS`: asynchronous raw pad inputs.
- `debounced_out`, output, `NUM_INPUTS`: filtered stable level. Registered.
- `rise_pulse`, output, `NUM_INPUTS`: one-cycle strobe when a bit's `debounced_out` goes 0→1. Registered.
- `fall_pulse`, output, `NUM_INPUTS`: one-cycle strobe when a bit's `debounced_out` goes 1→0. Registered.
- `any_change`, output, 1: OR of all `rise_pulse` and `fall_pulse` bits. Registered, same cycle as the strobes.

## Operation

**Per-channel structure (fully independent)**
- Two-flop synchroniser: `raw_in` → `sync1` → `sync2`.
- Counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Stable register, which is `debounced_out`.

**Each cycle (not in reset)**
- If `sync2 == debounced_out`: `cnt` ← 0, no pulses.
- If `sync2 != debounced_out` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
- If `sync2 != debounced_out` and `cnt == DEBOUNCE_CYCLES-1`:
  - `debounced_out` ← `sync2`, and `cnt` ← 0.
  - Assert `rise_pulse` or `fall_pulse` (matching the new level) for exactly this cycle.
- Any single cycle of agreement during counting discards progress: `cnt` returns to 0. Counting is strictly consecutive.

**Other rules**
- `cnt` saturates by construction; it never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- Pulses are registered outputs, deasserted in every cycle other than the acceptance cycle. `rise_pulse` and `fall_pulse` are never both high for the same bit.
- Simultaneous acceptance on several channels is legal; each channel raises its own pulse, and `any_change` is high once.
- `DEBOUNCE_CYCLES == 1`: no filtering. The change is accepted on the first mismatching cycle.

**Reset (`rst` high at a clock edge)**
- `sync1` and `sync2` ← `RESET_VALUE`.
- `debounced_out` ← `RESET_VALUE`.
- All `cnt` ← 0.
- `rise_pulse`, `fall_pulse`, `any_change` ← 0.
- Reset asserted mid-count abandons the count; no pulse is generated at or after reset release for pre-reset activity.

## Timing

- Reset values: `debounced_out = RESET_VALUE`; `rise_pulse`, `fall_pulse`, `any_change` all 0.
- Latency: if `raw_in[i]` changes before edge k and stays constant, `sync2` holds the new value after edge k+1. `debounced_out[i]` and the pulse update at edge k+1+`DEBOUNCE_CYCLES`.
- A glitch of length < `DEBOUNCE_CYCLES` cycles at `sync2` never changes `debounced_out`.
- Pulse width is exactly 1 cycle. `any_change` is coincident with the pulses.
- No back-pressure and no handshake: the consumer must sample pulses every cycle.
- Reset is synchronous only; `rst` is sampled at the `sys_clk` edge like any other input.

## Test plan

Use `NUM_INPUTS=6`, `DEBOUNCE_CYCLES=4`, `RESET_VALUE=0` unless stated otherwise.

1. **Reset:** hold `rst` for 3 cycles with `raw_in=6'h3F`. Required: all outputs 0 during reset. After release, bits go high at the 1+1+4th edge with six `rise_pulse` bits and one `any_change`, each 1 cycle wide.
2. **Clean press:** `raw_in[0]` 0→1 before edge k. Required: `debounced_out[0]=1` and `rise_pulse[0]=1` at edge k+5 only. On release 1→0, `fall_pulse[0]` fires once, 5 edges later.
3. **Bounce:** toggle `raw_in[1]` with high for 3 cycles, low for 1, high for 2, then high steady. Required: no output change until 4 consecutive high cycles at `sync2`; exactly one `rise_pulse[1]`.
4. **Simultaneous channels:** `raw_in[2]` and `raw_in[5]` rise on the same cycle. Required: both bits update on the same edge; `rise_pulse=6'b100100`; `any_change` high for 1 cycle.
5. **Reset mid-count:** `raw_in[3]` rises, then `rst` is pulsed 2 cycles later (count at 1). Required: `debounced_out[3]` stays 0 through reset. After release, a full 2+4-cycle latency applies, giving one `rise_pulse[3]`.
6. **Parameter corners:** `DEBOUNCE_CYCLES=1` and `RESET_VALUE=6'h3F`. Required: reset level is all ones. A 1-cycle low glitch on `raw_in[4]` yields `fall_pulse[4]` then `rise_pulse[4]` on consecutive cycles, with no other bits affected.
